// File: rtl/dmem_pkg.sv
// Shared encodings for the data-RAM arbiter: access sizes, FSM states, port ids
// and the alignment rule used on latched commands.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_READ_WAIT = 2'd2
  } dmem_state_e;

  // Size 2'b11 has no legal encoding, so it is always reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: store enables/replicated data and
// load extraction with sign or zero extension.
module mem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_dout_i,
  output logic [3:0]  wea_o,
  output logic [31:0] din_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    wea_o   = 4'b0000;
    din_o   = wdata_i;
    rdata_o = ram_dout_i;
    byte_v  = ram_dout_i[{off_i, 3'b000} +: 8];
    half_v  = off_i[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        wea_o   = 4'b0001 << off_i;
        din_o   = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        wea_o   = 4'b0011 << off_i;
        din_o   = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        wea_o   = 4'b1111;
      end
      default: begin
        wea_o   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: grants one command,
// issues it for one cycle, and for loads waits one cycle for RAM read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RR_EN  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        size0_i,
  input  logic [1:0]        size1_i,
  input  logic              uns0_i,
  input  logic              uns1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic [1:0]        err_o,
  output logic [31:0]       rdata_o,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output dmem_state_e       state_o
);

  // Handshake: a requester holds req_i[p] with stable command fields until
  // gnt_o[p] pulses; the command is latched on that edge, and exactly one of
  // done_o[p] / err_o[p] pulses later for it unless reset intervenes.

  dmem_state_e        state_q, state_d;
  logic               last_q, last_d;
  logic               port_q, port_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               win;
  logic [1:0]         port_mask;
  logic [3:0]         fmt_wea;
  logic [31:0]        fmt_rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{addr0_i[31:ADDR_W+2], addr1_i[31:ADDR_W+2]};
  assign port_mask = port_q ? 2'b10 : 2'b01;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign state_o   = state_q;

  mem_lane_fmt u_fmt (
    .size_i     (size_q),
    .uns_i      (uns_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .ram_dout_i (ram_dout),
    .wea_o      (fmt_wea),
    .din_o      (ram_din),
    .rdata_o    (fmt_rdata)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = 1'b0;
    gnt_o   = 2'b00;
    done_o  = 2'b00;
    err_o   = 2'b00;
    ram_wea = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          // On a tie, round-robin favours the port not granted last.
          if (req_i == 2'b11) win = (RR_EN != 0) ? ~last_q : 1'b0;
          else                win = req_i[1];
          gnt_o   = win ? 2'b10 : 2'b01;
          last_d  = win;
          port_d  = win;
          we_d    = we_i[win];
          size_d  = win ? size1_i : size0_i;
          uns_d   = win ? uns1_i : uns0_i;
          addr_d  = win ? addr1_i[ADDR_W+1:0] : addr0_i[ADDR_W+1:0];
          wdata_d = win ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_misaligned(size_q, addr_q[1:0])) begin
          err_o   = port_mask;
          state_d = S_IDLE;
        end else if (we_q) begin
          ram_wea = fmt_wea;
          done_o  = port_mask;
          state_d = S_IDLE;
        end else begin
          state_d = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        done_o  = port_mask;
        rdata_d = fmt_rdata;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset aborts whatever is in flight, including a write being issued.
    if (reset) begin
      gnt_o   = 2'b00;
      done_o  = 2'b00;
      err_o   = 2'b00;
      ram_wea = 4'b0000;
    end
    rdata_o = rdata_q;
    if (state_q == S_READ_WAIT && !reset) rdata_o = fmt_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (14-bit word address, 4-bit byte write enable, 32-bit data, 1-cycle read latency) between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA loader.
- Converts byte, halfword and word accesses into RAM word address plus byte-lane enables, and aligns and sign/zero-extends read data.
- Sits between the requesters and the RAM wrapper, and owns the RAM clock-domain-side port during normal mode.

Parameters:
- ADDR_W, 14, RAM word-address width; the byte address uses bits [ADDR_W+1:0].
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 always winning.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i[1:0]  in  2  per-port request; held high until the matching gnt_o.
- we_i[1:0]  in  2  per-port write (1) / read (0).
- size0_i, size1_i  in  2 each  00 = byte, 01 = halfword, 10 = word; 11 is treated as misaligned.
- uns0_i, uns1_i  in  1 each  1 = zero-extend loads, 0 = sign-extend loads.
- addr0_i, addr1_i  in  32 each  byte address.
- wdata0_i, wdata1_i  in  32 each  store data, right-justified.
- gnt_o[1:0]  out  2  one-cycle pulse: the command has been accepted and latched.
- done_o[1:0]  out  2  one-cycle pulse: transaction complete (read data valid or write committed).
- err_o[1:0]  out  2  one-cycle pulse, asserted instead of done_o on a misaligned access.
- rdata_o  out  32  formatted load data; valid only while done_o is nonzero for a read.
- ram_wea  out  4  byte write enables to the RAM.
- ram_addr  out  ADDR_W  RAM word address.
- ram_din  out  32  lane-replicated write data.
- ram_dout  in  32  RAM read data; valid one cycle after the address is presented.

Behaviour:
- Reset values:
  - Outputs gnt_o, done_o, err_o, ram_wea are 0. rdata_o, ram_addr, ram_din are 0.
  - State register is IDLE. The last-grant pointer is 1, so port 0 wins the first tie.
- Reset mid-transaction aborts it: no done_o, and ram_wea is forced to 0 in the reset cycle. A read or write already issued to the RAM is not reported.
- State machine: IDLE -> ISSUE -> (READ_WAIT for loads) -> IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests:
  - Winner: RR_EN=1 picks the port not granted last; RR_EN=0 picks port 0.
  - Pulse gnt_o[w]; latch we, size, uns, addr and wdata; go to ISSUE.
  - A request dropped before grant is legal and has no effect.
- Misalignment check, made on the latched command in ISSUE: halfword with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - On misalignment: ram_wea = 0, err_o[w] = 1, next state IDLE.
- ISSUE, aligned:
  - ram_addr = addr[ADDR_W+1:2].
  - Write:
    - Byte: ram_wea = 0001 shifted left by addr[1:0]; ram_din = {4{wdata[7:0]}}.
    - Halfword: ram_wea = 0011 << addr[1:0]; ram_din = {2{wdata[15:0]}}.
    - Word: ram_wea = 1111; ram_din = wdata.
    - done_o[w] = 1 in the same cycle; next state IDLE.
  - Read: ram_wea = 0; next state READ_WAIT.
- READ_WAIT:
  - ram_addr is held.
  - rdata_o is the byte/halfword selected by addr[1:0] from ram_dout, extended per uns; a word passes through.
  - done_o[w] = 1; next state IDLE.
- Outputs in other states:
  - ram_wea is 0 in every state except an aligned-write ISSUE.
  - rdata_o holds its last value outside done.
- Latency, from a request seen in IDLE:
  - Grant in cycle 0; store done or error in cycle 1; load done in cycle 2.
  - Back-to-back throughput: one store per 2 cycles, one load per 3 cycles.
- Simultaneous requests with RR_EN=1 alternate 0,1,0,1. A single requester is granted every transaction, with no forced idle.
- A new request arriving during ISSUE or READ_WAIT waits; it is evaluated in the next IDLE cycle.
- Address bits above ADDR_W+1 are ignored, so accesses wrap modulo the RAM size.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encodings S_IDLE, S_ISSUE, S_READ_WAIT.
  - Constant PORT_CPU=0, PORT_DBG=1.
- Sub-module mem_lane_fmt: purely combinational.
  - Store path: size and addr[1:0] -> wea and lane-replicated din.
  - Load path: size, uns, addr[1:0] and ram_dout -> rdata.
  - The FSM, arbiter and latch registers stay in dmem_arbiter.

Test Plan:
- Port 0 word store, addr 0x0000_0010, data 0xDEADBEEF -> gnt_o=01 at cycle 0; cycle 1 ram_addr=4, ram_wea=1111, ram_din=0xDEADBEEF, done_o=01.
- Port 1 byte store, addr 0x13, data 0x000000A5 -> ram_addr=4, ram_wea=1000, ram_din=0xA5A5A5A5. Then a port 0 signed byte load of addr 0x13 -> done_o=01 at cycle 2, rdata_o=0xFFFFFFA5. The same load with uns=1 -> 0x000000A5.
- Halfword load, addr 0x12, RAM word 0x8001_xxxx, uns=0 -> rdata_o=0xFFFF8001.
- Halfword store to addr 0x11 -> err_o pulses, ram_wea stays 0000, no done_o, FSM returns to IDLE. Word load to addr 0x2 -> err_o, no done_o.
- Both ports requesting continuously with RR_EN=1 -> grant sequence 01,10,01,10, gnt_o pulses spaced by transaction length. With RR_EN=0 -> port 0 granted every time, port 1 never granted.
- Assert reset while in READ_WAIT -> next cycle state IDLE, done_o=00, ram_wea=0000, rdata_o=0. A pending request is granted 1 cycle after reset deasserts, with port 0 winning a tie.
